// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: first-word-fall-through byte buffer behind the Uart8 receiver.
// It captures a byte on each rising edge of rxDone and drops frames that carry rxErr.
// It counts dropped error frames and keeps a sticky flag for bytes lost on overflow.
module uart8_rx_fifo #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rxDone,
   input  logic                  rxErr,
   input  logic [7:0]            in,
   output logic [7:0]            out,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  overflow,
   output logic [7:0]            errCount,
   input  logic                  clearFlags
);

   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [7:0]    ERR_MAX = 8'hFF;

   logic [7:0]            r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_valid;
   logic                  r_full;
   logic                  r_overflow;
   logic [7:0]            r_err_count;
   logic                  r_rx_done_prev;

   logic                  w_capture;
   logic                  w_good;
   logic                  w_bad;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [CW-1:0]         w_count_nxt;

   // Capture, push, pop and drop qualifiers; a pop frees a slot for a push in the same cycle.
   always_comb begin
      w_capture = rxDone & ~r_rx_done_prev;
      w_good    = w_capture & ~rxErr;
      w_bad     = w_capture & rxErr;
      w_pop     = r_valid & outReady;
      w_push    = w_good & (~r_full | w_pop);
      w_drop    = w_good & r_full & ~w_pop;
   end

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // Storage write; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in;
      end
   end

   // Pointers, occupancy and the registered valid/full status.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         r_full  <= (w_count_nxt == C_DEPTH);
      end
   end

   // Edge detector; it resets high so that an rxDone still held across reset is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_done_prev <= 1'b1;
      end else begin
         r_rx_done_prev <= rxDone;
      end
   end

   // Status flags; a set event in the same cycle as clearFlags takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clearFlags) begin
            r_overflow <= 1'b0;
         end
         if (w_bad) begin
            if (clearFlags) begin
               r_err_count <= 8'd1;
            end else if (r_err_count != ERR_MAX) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end else if (clearFlags) begin
            r_err_count <= '0;
         end
      end
   end

   assign out      = r_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign outValid = r_valid;
   assign count    = r_count;
   assign full     = r_full;
   assign overflow = r_overflow;
   assign errCount = r_err_count;

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// Directed testbench for uart8_rx_fifo with hand-computed expected values.
module tb_uart8_rx_fifo;

   logic       clk;
   logic       reset;
   logic       rxDone;
   logic       rxErr;
   logic [7:0] r_in;
   logic [7:0] out;
   logic       outValid;
   logic       outReady;
   logic [4:0] count;
   logic       full;
   logic       overflow;
   logic [7:0] errCount;
   logic       clearFlags;

   int n_tests = 0;
   int n_fail  = 0;

   uart8_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .rxDone(rxDone), .rxErr(rxErr), .in(r_in),
      .out(out), .outValid(outValid), .outReady(outReady), .count(count),
      .full(full), .overflow(overflow), .errCount(errCount), .clearFlags(clearFlags)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   // One rxDone pulse: rising edge captured on the first step, low on the second.
   task automatic capture(input logic [7:0] b, input logic err);
      r_in   = b;
      rxErr  = err;
      rxDone = 1'b1;
      step();
      rxDone = 1'b0;
      rxErr  = 1'b0;
      step();
   endtask

   task automatic pop_one();
      outReady = 1'b1;
      step();
      outReady = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rxDone = 1'b0; rxErr = 1'b0; r_in = 8'h00;
      outReady = 1'b0; clearFlags = 1'b0;
      #2;
      do_reset();
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(outValid), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_err", 32'(errCount), 0);
      chk("rst_out", 32'(out), 32'h00);

      // 1: long rxDone level produces a single push
      r_in = 8'hB5; rxDone = 1'b1;
      step();
      chk("t1_count_edge", 32'(count), 1);
      chk("t1_valid_edge", 32'(outValid), 1);
      chk("t1_out_edge", 32'(out), 32'hB5);
      for (int i = 0; i < 39; i++) step();
      rxDone = 1'b0;
      step();
      chk("t1_count_held", 32'(count), 1);
      chk("t1_ovf", 32'(overflow), 0);
      pop_one();
      chk("t1_count_pop", 32'(count), 0);
      outReady = 1'b1;
      step();
      outReady = 1'b0;
      chk("t1_empty_pop", 32'(count), 0);

      // 2: error frame is discarded and counted
      capture(8'hB5, 1'b1);
      chk("t2_count", 32'(count), 0);
      chk("t2_valid", 32'(outValid), 0);
      chk("t2_err", 32'(errCount), 1);
      clearFlags = 1'b1; step(); clearFlags = 1'b0;
      chk("t2_err_clr", 32'(errCount), 0);

      // 3: fill, overflow, in-order drain
      for (int i = 0; i < 16; i++) capture(8'(i), 1'b0);
      capture(8'hAA, 1'b0);
      chk("t3_full", 32'(full), 1);
      chk("t3_count", 32'(count), 16);
      chk("t3_ovf", 32'(overflow), 1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t3_rd%0d", i), 32'(out), 32'(i));
         pop_one();
      end
      chk("t3_count_end", 32'(count), 0);
      chk("t3_full_end", 32'(full), 0);
      chk("t3_valid_end", 32'(outValid), 0);
      chk("t3_ovf_sticky", 32'(overflow), 1);
      clearFlags = 1'b1; step(); clearFlags = 1'b0;
      chk("t3_ovf_clr", 32'(overflow), 0);

      // 4: push and pop together while full
      for (int i = 0; i < 16; i++) capture(8'(8'h10 + i), 1'b0);
      chk("t4_full", 32'(full), 1);
      outReady = 1'b1; r_in = 8'h5A; rxDone = 1'b1;
      step();
      outReady = 1'b0; rxDone = 1'b0;
      chk("t4_count", 32'(count), 16);
      chk("t4_ovf", 32'(overflow), 0);
      chk("t4_head", 32'(out), 32'h11);
      step();
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("t4_rd%0d", i), 32'(out), 32'(8'h11 + i));
         pop_one();
      end
      chk("t4_last", 32'(out), 32'h5A);
      pop_one();
      chk("t4_empty", 32'(count), 0);

      // 5: rxDone held across reset does not capture
      r_in = 8'h3C; rxDone = 1'b1;
      reset = 1'b1; step(); step(); reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("t5_no_capture", 32'(count), 0);
      rxDone = 1'b0; step();
      rxDone = 1'b1; step();
      chk("t5_count", 32'(count), 1);
      chk("t5_out", 32'(out), 32'h3C);
      rxDone = 1'b0; step();
      chk("t5_count_hold", 32'(count), 1);
      pop_one();

      // 6: error counter saturates; clear with a coincident error gives 1
      for (int i = 0; i < 300; i++) capture(8'hEE, 1'b1);
      chk("t6_sat", 32'(errCount), 255);
      chk("t6_count", 32'(count), 0);
      r_in = 8'hEE; rxErr = 1'b1; rxDone = 1'b1; clearFlags = 1'b1;
      step();
      rxDone = 1'b0; rxErr = 1'b0; clearFlags = 1'b0;
      chk("t6_clr_set", 32'(errCount), 1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
